fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer that drives the word-address port of the instruction memory and buffers fetched words for decode.
- Holds the fetch PC and reads one 32-bit instruction per cycle from the combinational-read instruction memory.
- Pushes each {PC, instruction} pair into a small prefetch queue and presents the queue head to decode over a valid/ready handshake.
- Handles PC redirects from branches and jumps, and faults on out-of-range fetches.

## Interface
Parameters:
- ADDR_WIDTH, 10, byte-address width of instruction memory; memory holds 2^ADDR_WIDTH bytes.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset; must be word-aligned.
- QUEUE_DEPTH, 4, prefetch queue entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- Enable  in  1  fetch permitted while high.
- ImemAddress  out  ADDR_WIDTH-2  word address to instruction memory = PC[ADDR_WIDTH-1:2].
- ImemInstr  in  32  instruction returned by memory in the same cycle.
- Redirect  in  1  load RedirectPC and flush queue.
- RedirectPC  in  32  new fetch PC.
- InstrValid  out  1  queue head valid.
- InstrReady  in  1  decode accepts head.
- Instr  out  32  head instruction.
- InstrPC  out  32  head PC.
- Fault  out  1  fetch fault latched.
- FaultPC  out  32  PC that caused the fault.

## Operation
- States: IDLE, RUN, FAULT.
- Reset: state IDLE, PC=RESET_PC, queue empty, InstrValid=0, Instr=0, InstrPC=0, Fault=0, FaultPC=0. ImemAddress follows PC.
- IDLE:
  - Enable=1 → RUN.
  - No pushes. The queue still drains to decode.
- RUN, per cycle, in priority order:
  1. Redirect=1: PC←RedirectPC, queue flushed, no push; any pop that cycle is discarded.
  2. PC[31:ADDR_WIDTH]≠0: no push; FAULT, Fault←1, FaultPC←PC.
  3. Push allowed (count<QUEUE_DEPTH, or count==QUEUE_DEPTH with a pop this cycle): push {PC, ImemInstr}, PC←PC+4 (32-bit wrap).
  4. Enable=0: → IDLE at the same edge. A push allowed in that cycle by rule 3 still happens.
- FAULT:
  - No pushes. The queue drains normally.
  - Redirect=1 → RUN, Fault←0, PC←RedirectPC, queue flushed.
  - Only Redirect or rst leaves FAULT.
- Redirect in IDLE: PC←RedirectPC, queue flushed, stays IDLE.
- Pop: InstrValid && InstrReady at the edge advances the head.
- Simultaneous push and pop when full is legal; count stays unchanged.
- Instr and InstrPC read the head entry and are stable while InstrValid=1 and InstrReady=0.
- Queue pointers wrap modulo QUEUE_DEPTH. Count spans 0..QUEUE_DEPTH.
- Reset mid-operation discards queue contents and in-flight state at that edge.

## Timing
- Fetch latency: Enable sampled high at edge E0 (→RUN); first push at E1; InstrValid=1 in the cycle after E1. Enable-to-valid is 2 cycles.
- Throughput: 1 instruction/cycle sustained when InstrReady is held high.
- Redirect at edge R: InstrValid=0 in the cycle after R. The first new-path instruction is pushed at R+1 and is valid after R+1.
- ImemAddress is combinational from the PC register only, never from Redirect inputs.
- Fault asserts the cycle after the edge that detected the out-of-range PC.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - In RUN or IDLE, a Redirect with RedirectPC[1:0]≠0 → FAULT, Fault←1, FaultPC←RedirectPC, queue flushed.
  - A misaligned Redirect while in FAULT keeps FAULT and updates FaultPC.
- Undefined: RedirectPC[1:0] is ignored; PC←{RedirectPC[31:2],2'b00}. No misalignment fault exists.

## Test plan
- Reset, memory words 0x00000013, 0x00100093, ... at 0x0,0x4,...; Enable=1, InstrReady=1 → InstrValid rises 2 cycles after Enable; InstrPC=0x0,0x4,0x8 on consecutive cycles; Instr matches memory.
- InstrReady=0 for 10 cycles → 4 pushes then count=4; ImemAddress frozen at word 4; head stays PC 0x0. Then InstrReady=1 → PCs 0x0..0xC drain with no gap, followed by 0x10.
- Redirect=1, RedirectPC=0x100 while queue holds 3 entries → InstrValid=0 the next cycle; following valid entry has InstrPC=0x100 and Instr=mem[0x100].
- ADDR_WIDTH=10, Redirect to 0x3FC → 0x3FC delivered; next PC 0x400 → Fault=1, FaultPC=0x400, no further pushes. Redirect to 0x0 → Fault=0 and fetch resumes.
- Redirect to 0x102: with FETCH_MISALIGN_CHECK_EN → Fault=1, FaultPC=0x102; without it → fetch from 0x100.
- rst asserted with a full queue and InstrReady=0 → next cycle InstrValid=0, state IDLE, ImemAddress=RESET_PC[ADDR_WIDTH-1:2].

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer feeding a prefetch queue to decode
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   Enable              fetch permitted while high
//   ImemAddress/Instr   word address to and instruction from a combinational-read memory
//   Redirect/RedirectPC load a new fetch PC and flush the queue
//   InstrValid/Ready    valid/ready handshake for the queue head (Instr, InstrPC)
//   Fault/FaultPC       latched fetch fault and the offending PC
// Optional: define FETCH_MISALIGN_CHECK_EN to fault on misaligned redirect targets.
module fetch_unit #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Enable,
    output logic [ADDR_WIDTH-3:0] ImemAddress,
    input  logic [31:0]           ImemInstr,
    input  logic                  Redirect,
    input  logic [31:0]           RedirectPC,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    output logic [31:0]           Instr,
    output logic [31:0]           InstrPC,
    output logic                  Fault,
    output logic [31:0]           FaultPC
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   q_pc  [QUEUE_DEPTH];
    logic [31:0]   q_ins [QUEUE_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          pop, push, oob, misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign = |RedirectPC[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign ImemAddress = pc[ADDR_WIDTH-1:2];
    assign InstrValid  = count != '0;
    assign Instr       = InstrValid ? q_ins[head] : '0;
    assign InstrPC     = InstrValid ? q_pc[head] : '0;
    assign pop         = InstrValid && InstrReady;
    assign oob         = (pc >> ADDR_WIDTH) != '0;
    // A full queue still accepts a push when the head leaves at the same edge.
    assign push        = state == RUN && !Redirect && !oob && (count < CW'(QUEUE_DEPTH) || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[tail]  <= pc;
            q_ins[tail] <= ImemInstr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            Fault   <= 1'b0;
            FaultPC <= '0;
        end else begin
            // A redirect flushes the queue and discards any pop of that cycle.
            if (Redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (pop) head <= head + 1'b1;
                if (push) tail <= tail + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
            case (state)
                IDLE: begin
                    if (Redirect && misalign) begin
                        state   <= FAULT;
                        Fault   <= 1'b1;
                        FaultPC <= RedirectPC;
                    end else if (Redirect) pc <= RedirectPC & ~32'h3;
                    else if (Enable) state <= RUN;
                end
                RUN: begin
                    if (Redirect && misalign) begin
                        state   <= FAULT;
                        Fault   <= 1'b1;
                        FaultPC <= RedirectPC;
                    end else if (Redirect) pc <= RedirectPC & ~32'h3;
                    else if (oob) begin
                        state   <= FAULT;
                        Fault   <= 1'b1;
                        FaultPC <= pc;
                    end else begin
                        if (push) pc <= pc + 32'd4;
                        if (!Enable) state <= IDLE;
                    end
                end
                default: begin
                    if (Redirect && misalign) FaultPC <= RedirectPC;
                    else if (Redirect) begin
                        state <= RUN;
                        Fault <= 1'b0;
                        pc    <= RedirectPC & ~32'h3;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, Enable, Redirect, InstrReady;
    logic [31:0] RedirectPC, ImemInstr, Instr, InstrPC, FaultPC;
    logic [7:0]  ImemAddress;
    logic        InstrValid, Fault;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .Enable(Enable), .ImemAddress(ImemAddress),
        .ImemInstr(ImemInstr), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .Instr(Instr),
        .InstrPC(InstrPC), .Fault(Fault), .FaultPC(FaultPC)
    );

    function automatic logic [31:0] word_of(input logic [31:0] p);
        return (p >> 2) * 32'h0010_0080 + 32'h13;
    endfunction

    assign ImemInstr = word_of({22'd0, ImemAddress, 2'b00});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] target);
        Redirect   = 1'b1;
        RedirectPC = target;
        step();
        Redirect   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; Enable = 1'b0; Redirect = 1'b0; InstrReady = 1'b0; RedirectPC = '0;
        step(); step();
        check("rst_valid", 32'(InstrValid), 0);
        check("rst_instr", Instr, 0);
        check("rst_pc", InstrPC, 0);
        check("rst_fault", 32'(Fault), 0);
        check("rst_faultpc", FaultPC, 0);
        check("rst_addr", 32'(ImemAddress), 0);

        rst = 1'b0; Enable = 1'b1; InstrReady = 1'b1;
        step();
        check("lat_e0_valid", 32'(InstrValid), 0);
        step();
        for (int i = 0; i < 3; i++) begin
            check("seq_valid", 32'(InstrValid), 1);
            check("seq_pc", InstrPC, 32'(4 * i));
            check("seq_instr", Instr, word_of(32'(4 * i)));
            step();
        end

        InstrReady = 1'b0;
        redirect(32'h0);
        check("stall_flush", 32'(InstrValid), 0);
        for (int i = 0; i < 10; i++) step();
        check("stall_addr", 32'(ImemAddress), 4);
        check("stall_head", InstrPC, 0);
        InstrReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 32'(InstrValid), 1);
            check("drain_pc", InstrPC, 32'(4 * i));
            step();
        end

        InstrReady = 1'b0;
        redirect(32'h0);
        for (int i = 0; i < 3; i++) step();
        check("q3_head", InstrPC, 0);
        InstrReady = 1'b1;
        redirect(32'h100);
        check("redir_gap", 32'(InstrValid), 0);
        step();
        check("redir_valid", 32'(InstrValid), 1);
        check("redir_pc", InstrPC, 32'h100);
        check("redir_instr", Instr, word_of(32'h100));

        redirect(32'h3FC);
        step();
        check("edge_pc", InstrPC, 32'h3FC);
        check("edge_instr", Instr, word_of(32'h3FC));
        check("edge_nofault", 32'(Fault), 0);
        step();
        check("oob_fault", 32'(Fault), 1);
        check("oob_faultpc", FaultPC, 32'h400);
        step(); step();
        check("oob_nopush", 32'(InstrValid), 0);
        redirect(32'h0);
        check("recover_fault", 32'(Fault), 0);
        step();
        check("recover_pc", InstrPC, 0);

        redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("mis_fault", 32'(Fault), 1);
        check("mis_faultpc", FaultPC, 32'h102);
        redirect(32'h0);
`else
        check("mis_addr", 32'(ImemAddress), 32'h40);
        step();
        check("mis_pc", InstrPC, 32'h100);
`endif

        InstrReady = 1'b0;
        redirect(32'h0);
        for (int i = 0; i < 6; i++) step();
        check("full_valid", 32'(InstrValid), 1);
        rst = 1'b1;
        step();
        check("mid_rst_valid", 32'(InstrValid), 0);
        check("mid_rst_addr", 32'(ImemAddress), 0);
        rst = 1'b0; Enable = 1'b0;
        step(); step();
        check("idle_nopush", 32'(InstrValid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
